// File: rtl/backsub_mem_responder.sv
// Memory-side responder for the back-substitution solver bus: holds n, A, Y and x,
// answers solver reads combinationally, and controls the solver's reset release.
module backsub_mem_responder #(
    parameter int W     = 20,
    parameter int N_MAX = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_en,
    input  logic [1:0]   ld_sel,
    input  logic [W-1:0] ld_i,
    input  logic [W-1:0] ld_j,
    input  logic [W-1:0] ld_data,
    input  logic         go,
    input  logic         clr,
    input  logic [2:0]   opcode,
    input  logic [W-1:0] i,
    input  logic [W-1:0] j,
    input  logic [W-1:0] out_data,
    input  logic         fin,
    output logic [W-1:0] in_data,
    output logic         solver_rst_n,
    output logic         busy,
    output logic         done,
    output logic [2:0]   err,
    input  logic [W-1:0] rd_i,
    output logic [W-1:0] rd_data,
    output logic [15:0]  cyc_cnt,
    output logic [7:0]   wr_cnt
);

    localparam int IW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam logic [W-1:0] NMAX_W = W'(N_MAX);

    localparam logic [2:0] OP_GET_N = 3'b000;
    localparam logic [2:0] OP_RD_Y  = 3'b001;
    localparam logic [2:0] OP_RD_A  = 3'b010;
    localparam logic [2:0] OP_RD_X  = 3'b011;
    localparam logic [2:0] OP_WR_X  = 3'b100;

    localparam logic [1:0] SEL_N = 2'b00;
    localparam logic [1:0] SEL_Y = 2'b01;
    localparam logic [1:0] SEL_A = 2'b10;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t state;

    logic [W-1:0] n_reg;
    logic [W-1:0] a_mem [N_MAX][N_MAX];
    logic [W-1:0] y_mem [N_MAX];
    logic [W-1:0] x_mem [N_MAX];

    logic [IW-1:0] i_idx, j_idx, ld_i_idx, ld_j_idx, rd_idx;
    logic          i_ok, j_ok, ld_i_ok, ld_j_ok, rd_ok;

    logic          ld_n_we, ld_y_we, ld_a_we, x_we, go_ok;
    logic [W-1:0]  n_next;
    logic          n_next_ok;
    logic [2:0]    err_set;

    // Solver indices are checked against the live n; host indices against array bounds.
    assign i_idx    = i[IW-1:0];
    assign j_idx    = j[IW-1:0];
    assign ld_i_idx = ld_i[IW-1:0];
    assign ld_j_idx = ld_j[IW-1:0];
    assign rd_idx   = rd_i[IW-1:0];

    assign i_ok    = (i < n_reg);
    assign j_ok    = (j < n_reg);
    assign ld_i_ok = (ld_i < NMAX_W);
    assign ld_j_ok = (ld_j < NMAX_W);
    assign rd_ok   = (rd_i < NMAX_W);

    always_comb begin
        ld_n_we   = 1'b0;
        ld_y_we   = 1'b0;
        ld_a_we   = 1'b0;
        x_we      = 1'b0;
        go_ok     = 1'b0;
        err_set   = 3'b000;
        n_next    = n_reg;
        n_next_ok = 1'b0;
        if (state == ST_LOAD) begin
            if (ld_en) begin
                case (ld_sel)
                    SEL_N: ld_n_we = 1'b1;
                    SEL_Y: begin
                        ld_y_we    = ld_i_ok;
                        err_set[1] = !ld_i_ok;
                    end
                    SEL_A: begin
                        ld_a_we    = ld_i_ok && ld_j_ok;
                        err_set[1] = !(ld_i_ok && ld_j_ok);
                    end
                    default: err_set[2] = 1'b1;
                endcase
            end
            // A load of n in the same cycle as go is seen by go.
            n_next    = ld_n_we ? ld_data : n_reg;
            n_next_ok = (n_next != '0) && (n_next <= NMAX_W);
            if (go) begin
                go_ok      = n_next_ok;
                err_set[0] = !n_next_ok;
            end
        end else if (state == ST_RUN) begin
            err_set[2] = ld_en;
            case (opcode)
                OP_GET_N: begin
                end
                OP_RD_Y, OP_RD_X: err_set[1] = !i_ok;
                OP_RD_A: err_set[1] = !(i_ok && j_ok);
                OP_WR_X: begin
                    x_we       = i_ok;
                    err_set[1] = !i_ok;
                end
                default: err_set[2] = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_LOAD;
            solver_rst_n <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (go_ok) begin
                        state        <= ST_RUN;
                        solver_rst_n <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fin) begin
                        state        <= ST_DONE;
                        solver_rst_n <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (clr) begin
                        state <= ST_LOAD;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_LOAD;
                    solver_rst_n <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_reg <= '0;
            for (int r = 0; r < N_MAX; r++) begin
                y_mem[r] <= '0;
                for (int c = 0; c < N_MAX; c++) begin
                    a_mem[r][c] <= '0;
                end
            end
        end else begin
            if (ld_n_we) n_reg <= ld_data;
            if (ld_y_we) y_mem[ld_i_idx] <= ld_data;
            if (ld_a_we) a_mem[ld_i_idx][ld_j_idx] <= ld_data;
        end
    end

    // x is wiped at the start of every run so stale results never leak into readback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < N_MAX; r++) begin
                x_mem[r] <= '0;
            end
        end else if (go_ok) begin
            for (int r = 0; r < N_MAX; r++) begin
                x_mem[r] <= '0;
            end
        end else if (x_we) begin
            x_mem[i_idx] <= out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            wr_cnt  <= '0;
        end else if (go_ok) begin
            cyc_cnt <= '0;
            wr_cnt  <= '0;
        end else if (state == ST_RUN) begin
            if (cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
            if (x_we && (wr_cnt != 8'hFF)) wr_cnt <= wr_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 3'b000;
        end else begin
            err <= err | err_set;
        end
    end

    // Zero-latency read port: the solver samples in_data in the cycle it drives opcode.
    always_comb begin
        in_data = '0;
        if (state == ST_RUN) begin
            case (opcode)
                OP_GET_N: in_data = n_reg;
                OP_RD_Y:  if (i_ok) in_data = y_mem[i_idx];
                OP_RD_A:  if (i_ok && j_ok) in_data = a_mem[i_idx][j_idx];
                OP_RD_X:  if (i_ok) in_data = x_mem[i_idx];
                default:  in_data = '0;
            endcase
        end
    end

    assign rd_data = rd_ok ? x_mem[rd_idx] : '0;

endmodule

// File: tb/tb_backsub_mem_responder.sv
// Scoreboard bench for backsub_mem_responder: a behavioural memory/FSM model and a
// bench-side back-substitution solver drive the bus; a negedge monitor checks outputs.
module tb_backsub_mem_responder;

    localparam int W     = 20;
    localparam int N_MAX = 8;
    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ld_en;
    logic [1:0]   ld_sel;
    logic [W-1:0] ld_i, ld_j, ld_data;
    logic         go, clr;
    logic [2:0]   opcode;
    logic [W-1:0] bus_i, bus_j, out_data;
    logic         fin;
    logic [W-1:0] in_data;
    logic         solver_rst_n, busy, done;
    logic [2:0]   err;
    logic [W-1:0] rd_i, rd_data;
    logic [15:0]  cyc_cnt;
    logic [7:0]   wr_cnt;

    always #5 clk = ~clk;

    backsub_mem_responder #(.W(W), .N_MAX(N_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_i(ld_i), .ld_j(ld_j), .ld_data(ld_data),
        .go(go), .clr(clr),
        .opcode(opcode), .i(bus_i), .j(bus_j), .out_data(out_data), .fin(fin),
        .in_data(in_data), .solver_rst_n(solver_rst_n), .busy(busy), .done(done),
        .err(err), .rd_i(rd_i), .rd_data(rd_data), .cyc_cnt(cyc_cnt), .wr_cnt(wr_cnt)
    );

    typedef enum int {K_IN_DATA, K_RD_DATA, K_ERR, K_BUSY, K_DONE, K_SRST, K_WRCNT, K_CYC} kind_t;
    typedef struct {
        string       name;
        kind_t       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   num_checks = 0;
    int   num_fail   = 0;

    int           m_state;
    logic [W-1:0] m_n;
    logic [W-1:0] m_a [N_MAX][N_MAX];
    logic [W-1:0] m_y [N_MAX];
    logic [W-1:0] m_x [N_MAX];
    logic [W-1:0] r_x [N_MAX];
    logic [2:0]   m_err;
    int           m_cyc, m_wr;

    function automatic logic [31:0] actual(kind_t k);
        case (k)
            K_IN_DATA: return 32'(in_data);
            K_RD_DATA: return 32'(rd_data);
            K_ERR:     return 32'(err);
            K_BUSY:    return 32'(busy);
            K_DONE:    return 32'(done);
            K_SRST:    return 32'(solver_rst_n);
            K_WRCNT:   return 32'(wr_cnt);
            default:   return 32'(cyc_cnt);
        endcase
    endfunction

    task automatic push_exp(input string name, input kind_t k, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.kind = k;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Monitor: drains every pending expectation at the falling edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = actual(e.kind);
            num_checks++;
            if (act !== e.exp) begin
                num_fail++;
                $display("[TB] FAIL %s: actual=%0h required=%0h", e.name, act, e.exp);
            end
        end
    end

    function automatic logic [W-1:0] exp_in_data(input logic [2:0] op, input logic [W-1:0] ii,
                                                 input logic [W-1:0] jj);
        if (m_state != M_RUN) return '0;
        case (op)
            3'd0: return m_n;
            3'd1: return (ii < m_n) ? m_y[int'(ii)] : '0;
            3'd2: return (ii < m_n && jj < m_n) ? m_a[int'(ii)][int'(jj)] : '0;
            3'd3: return (ii < m_n) ? m_x[int'(ii)] : '0;
            default: return '0;
        endcase
    endfunction

    task automatic idle_inputs();
        ld_en = 1'b0; ld_sel = 2'b00; ld_i = '0; ld_j = '0; ld_data = '0;
        go = 1'b0; clr = 1'b0; fin = 1'b0;
        opcode = 3'd0; bus_i = '0; bus_j = '0; out_data = '0; rd_i = '0;
    endtask

    // One clock: update the reference model from the driven inputs, then advance.
    task automatic applyStimulus();
        if (!rst_n) begin
            m_state = M_LOAD; m_n = '0; m_err = '0; m_cyc = 0; m_wr = 0;
            for (int r = 0; r < N_MAX; r++) begin
                m_y[r] = '0; m_x[r] = '0;
                for (int c = 0; c < N_MAX; c++) m_a[r][c] = '0;
            end
        end else if (m_state == M_LOAD) begin
            if (ld_en) begin
                case (ld_sel)
                    2'd0: m_n = ld_data;
                    2'd1: if (ld_i < N_MAX) m_y[int'(ld_i)] = ld_data; else m_err[1] = 1'b1;
                    2'd2: if (ld_i < N_MAX && ld_j < N_MAX) m_a[int'(ld_i)][int'(ld_j)] = ld_data;
                          else m_err[1] = 1'b1;
                    default: m_err[2] = 1'b1;
                endcase
            end
            if (go) begin
                if (m_n >= 1 && m_n <= N_MAX) begin
                    m_state = M_RUN; m_cyc = 0; m_wr = 0;
                    for (int r = 0; r < N_MAX; r++) m_x[r] = '0;
                end else begin
                    m_err[0] = 1'b1;
                end
            end
        end else if (m_state == M_RUN) begin
            if (m_cyc < 65535) m_cyc++;
            if (ld_en) m_err[2] = 1'b1;
            case (opcode)
                3'd0: ;
                3'd1, 3'd3: if (bus_i >= m_n) m_err[1] = 1'b1;
                3'd2: if (bus_i >= m_n || bus_j >= m_n) m_err[1] = 1'b1;
                3'd4: begin
                    if (bus_i < m_n) begin
                        m_x[int'(bus_i)] = out_data;
                        if (m_wr < 255) m_wr++;
                    end else begin
                        m_err[1] = 1'b1;
                    end
                end
                default: m_err[2] = 1'b1;
            endcase
            if (fin) m_state = M_DONE;
        end else begin
            if (clr) m_state = M_LOAD;
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic checkOutput(input string name);
        push_exp({name, ".busy"}, K_BUSY, 32'(m_state == M_RUN));
        push_exp({name, ".done"}, K_DONE, 32'(m_state == M_DONE));
        push_exp({name, ".srst"}, K_SRST, 32'(m_state == M_RUN));
        push_exp({name, ".err"},  K_ERR,  32'(m_err));
        push_exp({name, ".wr"},   K_WRCNT, 32'(m_wr));
        push_exp({name, ".cyc"},  K_CYC,  32'(m_cyc));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [1:0] sel, input int ii, input int jj, input logic [W-1:0] d);
        ld_en = 1'b1; ld_sel = sel; ld_i = W'(ii); ld_j = W'(jj); ld_data = d;
        applyStimulus();
    endtask

    task automatic solver_read(input logic [2:0] op, input int ii, input int jj,
                               output logic [W-1:0] v, input string name);
        opcode = op; bus_i = W'(ii); bus_j = W'(jj);
        #1;
        v = in_data;
        push_exp(name, K_IN_DATA, 32'(exp_in_data(op, W'(ii), W'(jj))));
        applyStimulus();
    endtask

    // Bench-side solver: x[k] = Y[k] - sum_{c>k} A[k][c]*x[c], using only the bus.
    task automatic run_solver();
        logic [W-1:0] nn, acc, av, xv;
        int waited, nn_i;
        waited = 0;
        while (!solver_rst_n && waited < 20) begin
            applyStimulus();
            waited++;
        end
        if (!solver_rst_n) begin
            num_checks++;
            num_fail++;
            $display("[TB] FAIL solver_start: actual=solver_rst_n low required=high within 20 cycles");
            return;
        end
        solver_read(3'd0, 0, 0, nn, "solver.n");
        nn_i = (nn > N_MAX) ? N_MAX : int'(nn);
        for (int k = nn_i - 1; k >= 0; k--) begin
            solver_read(3'd1, k, 0, acc, "solver.y");
            for (int c = k + 1; c < nn_i; c++) begin
                solver_read(3'd2, k, c, av, "solver.a");
                solver_read(3'd3, c, 0, xv, "solver.x");
                acc = acc - av * xv;
            end
            opcode = 3'd4; bus_i = W'(k); out_data = acc;
            applyStimulus();
        end
        fin = 1'b1;
        applyStimulus();
    endtask

    task automatic ref_solve();
        logic [W-1:0] acc;
        for (int r = 0; r < N_MAX; r++) r_x[r] = '0;
        for (int k = int'(m_n) - 1; k >= 0; k--) begin
            acc = m_y[k];
            for (int c = k + 1; c < int'(m_n); c++) acc = acc - m_a[k][c] * r_x[c];
            r_x[k] = acc;
        end
    endtask

    task automatic check_readback(input string name);
        ref_solve();
        for (int k = 0; k < N_MAX; k++) begin
            rd_i = W'(k);
            push_exp($sformatf("%s.x%0d", name, k), K_RD_DATA, 32'((k < int'(m_n)) ? r_x[k] : '0));
            applyStimulus();
        end
        rd_i = W'(N_MAX + 5);
        push_exp({name, ".x_oob"}, K_RD_DATA, 32'd0);
        applyStimulus();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] v;
        int n;
        rst_n = 1'b0;
        idle_inputs();

        $display("[TB] reset state");
        do_reset();
        checkOutput("reset");
        for (int op = 0; op < 8; op++) begin
            opcode = 3'(op);
            push_exp($sformatf("reset.in_data_op%0d", op), K_IN_DATA, 32'd0);
            applyStimulus();
        end

        $display("[TB] 2x2 system");
        do_reset();
        load(2'd0, 0, 0, 2);
        load(2'd2, 0, 0, 1); load(2'd2, 0, 1, 3); load(2'd2, 1, 1, 1);
        load(2'd1, 0, 0, 11); load(2'd1, 1, 0, 2);
        go = 1'b1;
        applyStimulus();
        checkOutput("t2.go");
        run_solver();
        checkOutput("t2.done");
        push_exp("t2.wr_const", K_WRCNT, 32'd2);
        push_exp("t2.err_const", K_ERR, 32'd0);
        rd_i = W'(0); push_exp("t2.x0", K_RD_DATA, 32'd5); applyStimulus();
        rd_i = W'(1); push_exp("t2.x1", K_RD_DATA, 32'd2); applyStimulus();

        $display("[TB] 3x3 system, go with n load");
        do_reset();
        load(2'd2, 0, 0, 1); load(2'd2, 0, 1, 2); load(2'd2, 0, 2, 1);
        load(2'd2, 1, 1, 1); load(2'd2, 1, 2, 1); load(2'd2, 2, 2, 1);
        load(2'd1, 0, 0, 10); load(2'd1, 1, 0, 5); load(2'd1, 2, 0, 3);
        ld_en = 1'b1; ld_sel = 2'd0; ld_data = W'(3); go = 1'b1;
        applyStimulus();
        checkOutput("t3.go");
        run_solver();
        checkOutput("t3.done");
        push_exp("t3.wr_const", K_WRCNT, 32'd3);
        check_readback("t3");
        clr = 1'b1;
        applyStimulus();
        checkOutput("t3.clr");
        rd_i = W'(2); push_exp("t3.kept_x2", K_RD_DATA, 32'd3); applyStimulus();

        $display("[TB] bad n on go");
        do_reset();
        go = 1'b1;
        applyStimulus();
        checkOutput("t4.n0");
        ld_en = 1'b1; ld_sel = 2'd0; ld_data = W'(9); go = 1'b1;
        applyStimulus();
        checkOutput("t4.n9");
        push_exp("t4.err_const", K_ERR, 32'd1);

        $display("[TB] run-time faults and read-after-write");
        do_reset();
        load(2'd0, 0, 0, 2);
        go = 1'b1;
        applyStimulus();
        opcode = 3'd4; bus_i = W'(7); out_data = W'(5);
        applyStimulus();
        checkOutput("t5.bad_wr");
        solver_read(3'd3, 0, 0, v, "t5.x0");
        solver_read(3'd3, 1, 0, v, "t5.x1");
        opcode = 3'd4; bus_i = W'(1); out_data = W'(42);
        applyStimulus();
        opcode = 3'd3; bus_i = W'(1);
        push_exp("t6.raw", K_IN_DATA, 32'd42);
        applyStimulus();
        ld_en = 1'b1; ld_sel = 2'd1;
        applyStimulus();
        checkOutput("t6.ld_in_run");
        opcode = 3'd6;
        applyStimulus();
        for (int k = 0; k < 260; k++) begin
            opcode = 3'd4; bus_i = '0; out_data = W'($urandom());
            applyStimulus();
        end
        checkOutput("t6.wr_sat");
        solver_read(3'd3, 0, 0, v, "t6.x0_last");
        fin = 1'b1;
        applyStimulus();
        checkOutput("t6.done");
        go = 1'b1;
        applyStimulus();
        checkOutput("t6.go_in_done");
        clr = 1'b1;
        applyStimulus();
        checkOutput("t6.clr");
        clr = 1'b1;
        applyStimulus();
        checkOutput("t6.clr_in_load");
        go = 1'b1;
        applyStimulus();
        checkOutput("t6.rerun");
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        checkOutput("t6.midrun_reset");

        $display("[TB] randomized systems");
        for (int rep = 0; rep < 4; rep++) begin
            do_reset();
            load(2'($urandom_range(1, 3)), $urandom_range(0, 15), $urandom_range(0, 15), W'($urandom()));
            n = $urandom_range(1, N_MAX);
            for (int r = 0; r < n; r++) begin
                load(2'd1, r, 0, W'($urandom()));
                load(2'd2, r, r, W'(1));
                for (int c = r + 1; c < n; c++) load(2'd2, r, c, W'($urandom()));
            end
            load(2'd0, 0, 0, W'(n));
            go = 1'b1;
            applyStimulus();
            run_solver();
            checkOutput($sformatf("rand%0d", rep));
            check_readback($sformatf("rand%0d", rep));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
